// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 4-digit 7-segment scanner.
package disp_pkg;

    localparam int unsigned REFRESH_DIV_DEFAULT = 100000;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 4;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [AN_W-1:0]  an;
        logic [SEG_W-1:0] seg;
        logic             dp;
    } disp_out_t;

    localparam disp_out_t DISP_OFF = '{an: 4'b1111, seg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 4-bit value to active-low 7-segment pattern; 10-15 show a dash.
module seven_seg_decode
    import disp_pkg::*;
(
    input  logic [3:0]       value_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (value_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed MM:SS scanner: refresh divider, digit index, frame shadows,
// adjust-mode blinking and registered anode/cathode drive.
module display_scan
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       digit3,
    input  logic [3:0]       digit2,
    input  logic [2:0]       digit1,
    input  logic [3:0]       digit0,
    input  logic [1:0]       select,
    input  logic             isAdj,
    input  logic             twoHz,
    output logic [AN_W-1:0]  an,
    output logic [SEG_W-1:0] seg,
    output logic             dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             run_q, run_d;
    logic [2:0]       sh3_q, sh3_d;
    logic [3:0]       sh2_q, sh2_d;
    logic [2:0]       sh1_q, sh1_d;
    logic [3:0]       sh0_q, sh0_d;
    logic             sync1_q, sync2_q;
    disp_out_t        out_q, out_d;

    logic             tc;
    logic             wrap;
    logic             in_pair;
    logic             blank;
    logic [3:0]       cur_val;
    logic [SEG_W-1:0] dec_seg;

    // Only select[0] chooses the blink pair.
    logic unused_select;
    assign unused_select = select[1];

    seven_seg_decode u_decode (
        .value_i (cur_val),
        .seg_o   (dec_seg)
    );

    // run_q holds the scan idle after reset until the first terminal count, so index 0 is driven first.
    always_comb begin
        tc    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        run_d = run_q | tc;
        idx_d = idx_q;
        wrap  = tc && run_q && (idx_q == 2'd3);
        if (tc && run_q) begin
            idx_d = idx_q + 2'd1;
        end

        sh3_d = sh3_q;
        sh2_d = sh2_q;
        sh1_d = sh1_q;
        sh0_d = sh0_q;
        if (wrap) begin
            sh3_d = digit3;
            sh2_d = digit2;
            sh1_d = digit1;
            sh0_d = digit0;
        end

        case (idx_q)
            2'd0:    cur_val = sh0_q;
            2'd1:    cur_val = {1'b0, sh1_q};
            2'd2:    cur_val = sh2_q;
            default: cur_val = {1'b0, sh3_q};
        endcase

        in_pair = select[0] ? ~idx_q[1] : idx_q[1];
        blank   = isAdj && !sync2_q && in_pair;

        out_d = DISP_OFF;
        if (run_q) begin
            out_d.an = ~(4'b0001 << idx_q);
            if (!blank) begin
                out_d.seg = dec_seg;
                out_d.dp  = (idx_q != 2'd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            run_q   <= 1'b0;
            sh3_q   <= '0;
            sh2_q   <= '0;
            sh1_q   <= '0;
            sh0_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            out_q   <= DISP_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            sh3_q   <= sh3_d;
            sh2_q   <= sh2_d;
            sh1_q   <= sh1_d;
            sh0_q   <= sh0_d;
            sync1_q <= twoHz;
            sync2_q <= sync1_q;
            out_q   <= out_d;
        end
    end

    assign an  = out_q.an;
    assign seg = out_q.seg;
    assign dp  = out_q.dp;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan with REFRESH_DIV=4 (16-cycle frames).
module tb_display_scan;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] digit3 = '0;
    logic [3:0] digit2 = '0;
    logic [2:0] digit1 = '0;
    logic [3:0] digit0 = '0;
    logic [1:0] select = '0;
    logic       isAdj = 1'b0;
    logic       twoHz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    display_scan #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .digit3 (digit3),
        .digit2 (digit2),
        .digit1 (digit1),
        .digit0 (digit0),
        .select (select),
        .isAdj  (isAdj),
        .twoHz  (twoHz),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int i);
        case (i)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic push_slot(input int i, input int v, input bit blank, input int n);
        exp_t x;
        x.an  = an_of(i);
        x.seg = blank ? 7'b1111111 : seg7(v);
        x.dp  = (i == 2 && !blank) ? 1'b0 : 1'b1;
        repeat (n) exp_q.push_back(x);
    endtask

    task automatic push_frame(input int v0, input int v1, input int v2, input int v3,
                              input logic [3:0] bmask);
        push_slot(0, v0, bmask[0], 4);
        push_slot(1, v1, bmask[1], 4);
        push_slot(2, v2, bmask[2], 4);
        push_slot(3, v3, bmask[3], 4);
    endtask

    task automatic skip_frames(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        digit3 = 3'd5; digit2 = 4'd9; digit1 = 3'd4; digit0 = 4'd7;
        isAdj = 1'b0; select = 2'b00; twoHz = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({an, seg, dp} !== 12'hFFF) begin
            bad++;
            $display("FAIL reset_state got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp} !== 12'hFFF) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got an=%b seg=%b dp=%b want all off", k, an, seg, dp);
            end
        end
        push_frame(0, 0, 0, 0, 4'b0000);
        push_frame(7, 4, 9, 5, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL reset_frames cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_shadow;
        push_frame(7, 4, 9, 5, 4'b0000);
        push_frame(3, 4, 9, 5, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL shadow cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (k == 0) digit0 = 4'd3;
        end
    endtask

    task automatic test_blink;
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: begin isAdj = 1'b1; select = 2'b01; twoHz = 1'b0; push_frame(3, 4, 9, 5, 4'b0011); end
                1: begin twoHz = 1'b1; skip_frames(1); push_frame(3, 4, 9, 5, 4'b0000); end
                2: begin twoHz = 1'b0; select = 2'b11; skip_frames(1); push_frame(3, 4, 9, 5, 4'b0011); end
                default: begin select = 2'b00; push_frame(3, 4, 9, 5, 4'b1100); end
            endcase
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                total++;
                if ({an, seg, dp} !== e) begin
                    bad++;
                    $display("FAIL blink phase=%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             p, k, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    endtask

    task automatic test_no_adj;
        isAdj = 1'b0;
        select = 2'b01;
        push_frame(3, 4, 9, 5, 4'b0000);
        push_frame(3, 4, 9, 5, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL no_adj cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an, seg, dp, e.an, e.seg, e.dp);
            end
            twoHz = ~twoHz;
        end
    endtask

    task automatic test_immediate;
        isAdj = 1'b0; select = 2'b00; twoHz = 1'b0;
        skip_frames(1);
        push_slot(0, 3, 1'b0, 4);
        push_slot(1, 4, 1'b0, 4);
        push_slot(2, 9, 1'b0, 1);
        push_slot(2, 9, 1'b1, 3);
        push_slot(3, 5, 1'b1, 4);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL immediate cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (k == 8) isAdj = 1'b1;
        end
        isAdj = 1'b0;
    endtask

    task automatic test_dash;
        digit2 = 4'd12;
        digit3 = 3'd7;
        skip_frames(1);
        push_frame(3, 4, 12, 7, 4'b0000);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL dash cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_reset_mid;
        push_slot(0, 3, 1'b0, 4);
        push_slot(1, 4, 1'b0, 4);
        push_slot(2, 12, 1'b0, 1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL pre_reset cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({an, seg, dp} !== 12'hFFF) begin
            bad++;
            $display("FAIL mid_reset got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp} !== 12'hFFF) begin
                bad++;
                $display("FAIL mid_reset_idle cyc=%0d got an=%b seg=%b dp=%b want all off", k, an, seg, dp);
            end
        end
        push_frame(0, 0, 0, 0, 4'b0000);
        push_frame(3, 4, 12, 7, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shadow();
        test_blink();
        test_no_adj();
        test_immediate();
        test_dash();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
